// File: rtl/vadd_sat_avg_pipe.sv
// Vector add/sub lane with saturating, averaging and min/max ops, valid/ready handshake.
// Three register stages: operand capture, element result, output; sticky vxsat per instruction.
module vadd_sat_avg_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32,
    parameter bit SAT_ENABLE = 1'b1,
    parameter bit AVG_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_vec0,
    input  logic [DATA_WIDTH-1:0] in_vec1,
    input  logic [1:0]            in_sew,
    input  logic [3:0]            in_op,
    input  logic [1:0]            in_vxrm,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_req_end,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [BE_WIDTH-1:0]   out_be,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_req_end,
    output logic                  out_vxsat
);

    // Handshake: a beat moves on a rising edge iff valid & ready. The whole pipe
    // advances together unless the output holds a beat that downstream refuses.
    logic w_stall;
    logic w_advance;

    assign w_stall   = out_valid & ~out_ready;
    assign w_advance = ~w_stall;
    assign in_ready  = ~w_stall;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_vec0;
    logic [DATA_WIDTH-1:0] r_s1_vec1;
    logic [1:0]            r_s1_sew;
    logic [3:0]            r_s1_op;
    logic [1:0]            r_s1_vxrm;
    logic [BE_WIDTH-1:0]   r_s1_be;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic                  r_s1_end;

    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_vec;
    logic [BE_WIDTH-1:0]   r_s2_be;
    logic [ADDR_WIDTH-1:0] r_s2_addr;
    logic                  r_s2_end;
    logic                  r_s2_sat;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_vec;
    logic [BE_WIDTH-1:0]   r_out_be;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  r_out_end;
    logic                  r_out_vxsat;
    logic                  r_acc;

    logic w_is_plain, w_is_sgn, w_is_sub, w_is_sat, w_is_avg, w_is_min, w_is_max;

    assign w_is_plain = (r_s1_op == 4'd0) || (r_s1_op == 4'd1);
    assign w_is_sgn   = r_s1_op inside {4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13};
    assign w_is_sub   = r_s1_op inside {4'd1, 4'd4, 4'd5, 4'd8, 4'd9};
    assign w_is_sat   = r_s1_op inside {4'd2, 4'd3, 4'd4, 4'd5};
    assign w_is_avg   = r_s1_op inside {4'd6, 4'd7, 4'd8, 4'd9};
    assign w_is_min   = (r_s1_op == 4'd10) || (r_s1_op == 4'd11);
    assign w_is_max   = (r_s1_op == 4'd12) || (r_s1_op == 4'd13);

    // One full-width datapath per element size; the SEW mux picks one afterwards.
    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int EW = 8 << g;
        localparam int NE = DATA_WIDTH / EW;

        logic [DATA_WIDTH-1:0] w_res;
        logic [NE-1:0]         w_el_sat;
        logic [BE_WIDTH-1:0]   w_sat_b;

        for (genvar e = 0; e < NE; e++) begin : g_el
            logic [EW-1:0] w_a, w_b, w_out;
            logic [EW:0]   w_ea, w_eb, w_v;
            logic          w_lt, w_gt, w_rnd, w_sat;

            always_comb begin
                w_a   = r_s1_vec0[e*EW +: EW];
                w_b   = r_s1_vec1[e*EW +: EW];
                w_ea  = {w_is_sgn & w_a[EW-1], w_a};
                w_eb  = {w_is_sgn & w_b[EW-1], w_b};
                w_v   = w_is_sub ? (w_ea - w_eb) : (w_ea + w_eb);
                w_lt  = w_is_sgn ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b);
                w_gt  = w_is_sgn ? ($signed(w_b) < $signed(w_a)) : (w_b < w_a);
                w_out = '0;
                w_sat = 1'b0;
                w_rnd = 1'b0;
                case (r_s1_vxrm)
                    2'b00:   w_rnd = w_v[0];
                    2'b01:   w_rnd = w_v[0] & w_v[1];
                    2'b10:   w_rnd = 1'b0;
                    default: w_rnd = w_v[0] & ~w_v[1];
                endcase
                if (w_is_plain) begin
                    w_out = w_v[EW-1:0];
                end else if (w_is_sat) begin
                    if (SAT_ENABLE == 1'b0) begin
                        w_out = w_v[EW-1:0];
                    end else if (w_is_sgn) begin
                        // Signed overflow: the extra sign bit disagrees with the result MSB.
                        if (w_v[EW] != w_v[EW-1]) begin
                            w_sat = 1'b1;
                            w_out = w_v[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
                        end else begin
                            w_out = w_v[EW-1:0];
                        end
                    end else if (w_v[EW]) begin
                        w_sat = 1'b1;
                        w_out = w_is_sub ? '0 : '1;
                    end else begin
                        w_out = w_v[EW-1:0];
                    end
                end else if (w_is_avg) begin
                    if (AVG_ENABLE == 1'b1) begin
                        w_out = w_v[EW:1] + {{(EW-1){1'b0}}, w_rnd};
                    end
                end else if (w_is_min) begin
                    w_out = w_gt ? w_b : w_a;
                end else if (w_is_max) begin
                    w_out = w_lt ? w_b : w_a;
                end
            end

            assign w_res[e*EW +: EW] = w_out;
            assign w_el_sat[e]       = w_sat;
        end

        // An element's sat flag lives at its lowest byte so the byte enable can gate it.
        always_comb begin
            w_sat_b = '0;
            for (int k = 0; k < NE; k++) begin
                w_sat_b[k*(EW/8)] = w_el_sat[k];
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_res_sel;
    logic [BE_WIDTH-1:0]   w_sat_sel;
    logic [DATA_WIDTH-1:0] w_res_m;
    logic                  w_beat_sat;

    always_comb begin
        case (r_s1_sew)
            2'b00:   begin w_res_sel = g_sew[0].w_res; w_sat_sel = g_sew[0].w_sat_b; end
            2'b01:   begin w_res_sel = g_sew[1].w_res; w_sat_sel = g_sew[1].w_sat_b; end
            2'b10:   begin w_res_sel = g_sew[2].w_res; w_sat_sel = g_sew[2].w_sat_b; end
            default: begin w_res_sel = g_sew[3].w_res; w_sat_sel = g_sew[3].w_sat_b; end
        endcase
    end

    always_comb begin
        w_res_m = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            w_res_m[8*i +: 8] = r_s1_be[i] ? w_res_sel[8*i +: 8] : 8'h00;
        end
        w_beat_sat = |(w_sat_sel & r_s1_be);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_vec0   <= '0;
            r_s1_vec1   <= '0;
            r_s1_sew    <= '0;
            r_s1_op     <= '0;
            r_s1_vxrm   <= '0;
            r_s1_be     <= '0;
            r_s1_addr   <= '0;
            r_s1_end    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_vec    <= '0;
            r_s2_be     <= '0;
            r_s2_addr   <= '0;
            r_s2_end    <= 1'b0;
            r_s2_sat    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_be    <= '0;
            r_out_addr  <= '0;
            r_out_end   <= 1'b0;
            r_out_vxsat <= 1'b0;
            r_acc       <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_s1_vec0   <= in_vec0;
            r_s1_vec1   <= in_vec1;
            r_s1_sew    <= in_sew;
            r_s1_op     <= in_op;
            r_s1_vxrm   <= in_vxrm;
            r_s1_be     <= in_be;
            r_s1_addr   <= in_addr;
            r_s1_end    <= in_req_end;
            r_s2_valid  <= r_s1_valid;
            r_s2_vec    <= w_res_m;
            r_s2_be     <= r_s1_be;
            r_s2_addr   <= r_s1_addr;
            r_s2_end    <= r_s1_end;
            r_s2_sat    <= r_s1_valid & w_beat_sat;
            r_out_valid <= r_s2_valid;
            r_out_vec   <= r_s2_vec;
            r_out_be    <= r_s2_be;
            r_out_addr  <= r_s2_addr;
            r_out_end   <= r_s2_end;
            r_out_vxsat <= 1'b0;
            if (r_s2_valid) begin
                if (r_s2_end) begin
                    r_out_vxsat <= r_acc | r_s2_sat;
                    r_acc       <= 1'b0;
                end else begin
                    r_acc       <= r_acc | r_s2_sat;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_vec     = r_out_vec;
    assign out_be      = r_out_be;
    assign out_addr    = r_out_addr;
    assign out_req_end = r_out_end;
    assign out_vxsat   = r_out_vxsat;

endmodule

// File: doc/vadd_sat_avg_pipe.md
Name: vadd_sat_avg_pipe

Overview:
- Parametrised, back-pressurable successor to the vALU add/min/max lane.
- Performs element-wise integer add/sub, saturating add/sub (setting vxsat), averaging add/sub with all four vxrm rounding modes, and signed/unsigned min/max.
- Handles any DATA_WIDTH that is a multiple of 64 and SEW of 8/16/32/64.
- Sits between the vector issue/operand-read stage and the writeback arbiter; uses a valid/ready handshake instead of a fixed free-running pipe.

Parameters:
- DATA_WIDTH, 64, operand/result width in bits; must be a multiple of 64.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 32, width of the pass-through destination address.
- SAT_ENABLE, 1, when 0 saturating ops behave as plain add/sub and vxsat is never set.
- AVG_ENABLE, 1, when 0 averaging ops produce zero data.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_vec0  in  DATA_WIDTH  operand vs2.
- in_vec1  in  DATA_WIDTH  operand vs1/rs1 (already splatted).
- in_sew  in  2  00=8, 01=16, 10=32, 11=64 bit elements.
- in_op  in  4  opcode: 0 add, 1 sub, 2 saddu, 3 sadd, 4 ssubu, 5 ssub, 6 aaddu, 7 aadd, 8 asubu, 9 asub, 10 minu, 11 min, 12 maxu, 13 max; 14/15 reserved.
- in_vxrm  in  2  00 rnu, 01 rne, 10 rdn, 11 rod.
- in_be  in  BE_WIDTH  byte enables.
- in_addr  in  ADDR_WIDTH  destination address, passed through.
- in_req_end  in  1  last beat of the instruction.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts beat.
- out_vec  out  DATA_WIDTH  result.
- out_be  out  BE_WIDTH  byte enables, aligned with out_vec.
- out_addr  out  ADDR_WIDTH  destination address.
- out_req_end  out  1  last beat of the instruction.
- out_vxsat  out  1  on the end beat: any enabled element of the instruction saturated; 0 on all other beats.

Behaviour:
- Reset (rst low, asynchronous): every stage valid clears; out_valid, out_vec, out_be, out_addr, out_req_end, out_vxsat = 0; sticky sat accumulator = 0. in_ready = 1 while rst is high and no stall.
- Pipeline has three register stages:
  - S1: operand/control capture; forms SEW+1-bit raw sum/difference per element (unsigned zero-extend or signed sign-extend per op) plus per-element lt/eq.
  - S2: saturate, round or select.
  - Output register.
- Latency is 3 cycles from accepted beat to out_valid, with out_ready held high.
- Stall = out_valid & ~out_ready. While stalled, all stages hold and in_ready = 0; in_ready is combinational on out_ready. A beat is accepted iff in_valid & in_ready. Throughput is 1 beat/cycle, no bubbles inserted. Pipeline bubbles do not compress during a stall.
- Element arithmetic, per SEW lane, with no carry across element boundaries:
  - add/sub: wrap modulo 2^SEW.
  - saddu: clamp to 2^SEW-1; ssubu: clamp to 0.
  - sadd/ssub: clamp to 2^(SEW-1)-1 or -2^(SEW-1) on signed overflow.
  - Each clamp sets the element's sat bit.
- Averaging: v = SEW+1-bit raw result; out = v[SEW:1] + r. Rounding increment r by vxrm:
  - rnu: r = v[0]
  - rne: r = v[0] & v[1]
  - rdn: r = 0
  - rod: r = v[0] & ~v[1]
  - The result never overflows SEW bits.
- min/max: select vec0 or vec1 via signed/unsigned compare; equal operands return vec0.
- Reserved opcodes: data 0, sat bits 0, beat still passes with its be/addr.
- Masking: bytes with be=0 output 0. An element's sat bit counts only if its lowest byte is enabled.
- vxsat: sticky accumulator ORs the sat bits of each beat leaving S2.
  - On a beat with req_end, out_vxsat = accumulator | current-beat sat, and the accumulator clears as that beat enters the output register.
  - A new instruction's first beat arriving right after an end beat starts with a clear accumulator.
- Mid-operation reset drops all in-flight beats and clears the accumulator; no partial output.

Test Plan:
- SEW=8, saddu, vec0 byte0=0xF0, vec1 byte0=0x20, be=0xFF, req_end=1 -> byte0=0xFF, out_vxsat=1, result at cycle 3.
- SEW=8, aaddu, 0x05+0x00 for vxrm=rnu/rne/rdn/rod -> 0x03/0x02/0x02/0x03; out_vxsat=0.
- SEW=16, ssub, 0x8000-0x0001 -> 0x8000 and vxsat=1; same op with be=0xFC masking that element -> element 0x0000 and vxsat=0.
- SEW=8, min vs minu on 0x80 vs 0x7F -> 0x80 vs 0x7F; SEW=64 add 0xFFFF_FFFF_FFFF_FFFF+1 -> 0, no cross-element carry at other SEWs.
- Stream of 6 beats with out_ready low for cycles 4-7 -> in_ready low exactly while stalled, all 6 beats emerge in order with no loss or duplication.
- Two-beat saturating instruction with saturation only on beat 1, followed immediately by a non-saturating instruction; assert rst low mid-stream -> vxsat=1 only on the first end beat, 0 on the second; outputs zero immediately after reset.
